serial_add_sub: RTL and testbench
=================================

// Module: serial_add_sub
// PURPOSE
//  Bit-serial adder (optionally subtractor): latches two WIDTH-bit operands on start,
//  then processes one bit per clock, LSB first, through a single full_adder cell and a
//  registered carry. Area-lean arithmetic unit for slow datapaths.
//  Presents a parallel sum and carry when done; start/busy/done handshake toward the controller.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request; sampled only in IDLE
//  a          in   WIDTH  operand A, captured on accepted start
//  b          in   WIDTH  operand B, captured on accepted start
//  sub        in   1      1 = A-B; port exists only with SERIAL_SUB_EN
//  busy       out  1      high while state != IDLE
//  done       out  1      one-cycle pulse, result valid
//  sum        out  WIDTH  result; held until next accepted start
//  carry_out  out  1      final carry (add: overflow; sub: 1 = no borrow)
// BEHAVIOUR
//  - One clock, clk. Reset rst is synchronous, active-high.
//  - Reset (also mid-operation): state=IDLE, busy=0, done=0, sum=0, carry_out=0,
//    counter=0. Any partial result is discarded.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: if start, latch a->sa, b->sb, carry register=0, cnt=0; go RUN.
//    Accept cycle is T0.
//  - RUN: full_adder(a=sa[0], b=sb[0], c=carry_reg). Shift sa, sb right.
//    Shift sum bit into sum_sr at bit WIDTH-1 (right shift). carry_reg<=carry; cnt++.
//    On cnt==WIDTH-1, go DONE.
//  - DONE (cycle T0+WIDTH+1): done=1, sum=sum_sr, carry_out=carry_reg; next state IDLE.
//  - Latency: start accepted at T0 -> done high exactly WIDTH+1 cycles later.
//    busy high T0+1 .. T0+WIDTH+1 inclusive.
//  - start while busy (RUN or DONE) is ignored, not queued.
//    A new start is accepted the cycle after DONE.
//  - a/b may change freely after the accept cycle.
//  - sum/carry_out change only in DONE or on reset.
//  - Arithmetic is modulo 2^WIDTH; carry_out is bit WIDTH of the unsigned add.
//  - cnt is $clog2(WIDTH) bits; it never wraps past WIDTH-1.
// CONFIGURATION
//  SERIAL_SUB_EN defined:
//    - sub port present, latched on start.
//    - When sub=1: sb is loaded with ~b and carry_reg with 1 (two's complement A-B).
//    - carry_out=1 means A>=B unsigned.
//  SERIAL_SUB_EN undefined:
//    - No sub port; add only.
//    - No inversion logic is synthesised.
// STRUCTURE
//  - Shared package/include serial_arith_pkg:
//    - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
//    - the DEFAULT_WIDTH constant
//  - Sub-module: one instance of the existing full_adder
//    (ports a, b, c, sum, carry) as the per-bit cell.
//  - Everything else is in this block: FSM, shift registers, counter, carry register.
// TESTING
//  1. WIDTH=8, start, a=8'h35, b=8'h4A -> done 9 cycles later; sum=8'h7F, carry_out=0.
//  2. a=8'hFF, b=8'h01 -> sum=8'h00, carry_out=1.
//     Then start again the cycle after done; the second op is accepted.
//  3. SERIAL_SUB_EN, sub=1:
//     a=8'h10, b=8'h01 -> sum=8'h0F, carry_out=1.
//     a=8'h00, b=8'h01 -> sum=8'hFF, carry_out=0.
//  4. start pulsed again mid-RUN with different a/b -> ignored.
//     Result matches the first operands; exactly one done pulse.
//  5. rst asserted at cycle 4 of RUN -> next cycle busy=0, done=0, sum=0.
//     No done pulse follows.
//  6. WIDTH=3, all 64 a,b pairs (both sub values if enabled) -> {carry_out,sum}
//     equals a+b (or a+~b+1) for every pair.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic units: FSM state encoding and default width.
package serial_arith_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell: sum and carry of a + b + c.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);

   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial adder, LSB first through one full_adder cell, start/busy/done handshake.
// Define SERIAL_SUB_EN to add the sub port and two's-complement subtraction (A-B).
module serial_add_sub
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   sa;
   logic [WIDTH-1:0]   sb;
   logic [WIDTH-1:0]   sum_sr;
   logic [WIDTH-1:0]   sum_sr_nxt;
   logic               carry_reg;
   logic [CNT_W-1:0]   cnt;

   logic [WIDTH-1:0]   sb_load;
   logic               carry_load;
   logic               fa_sum;
   logic               fa_carry;

   // Operand B and carry-in as loaded on accept; subtraction feeds ~B with carry-in 1.
`ifdef SERIAL_SUB_EN
   always_comb begin
      sb_load    = sub ? ~b : b;
      carry_load = sub;
   end
`else
   always_comb begin
      sb_load    = b;
      carry_load = 1'b0;
   end
`endif

   full_adder u_fa (
      .a     (sa[0]),
      .b     (sb[0]),
      .c     (carry_reg),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // New sum bit enters at the MSB; the final shift lands directly in the result register.
   always_comb begin
      sum_sr_nxt = WIDTH'({fa_sum, sum_sr} >> 1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         sa        <= '0;
         sb        <= '0;
         sum_sr    <= '0;
         carry_reg <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  sa        <= a;
                  sb        <= sb_load;
                  carry_reg <= carry_load;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  state     <= ST_RUN;
               end
            end

            ST_RUN: begin
               sa        <= sa >> 1;
               sb        <= sb >> 1;
               sum_sr    <= sum_sr_nxt;
               carry_reg <= fa_carry;
               if (cnt == CNT_LAST) begin
                  sum       <= sum_sr_nxt;
                  carry_out <= fa_carry;
                  done      <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end

            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed self-checking bench for serial_add_sub (WIDTH=8 and WIDTH=3 instances).
module tb_serial_add_sub;

   logic       clk = 1'b0;
   logic       rst;
   logic       start8;
   logic [7:0] a8;
   logic [7:0] b8;
   logic       busy8;
   logic       done8;
   logic [7:0] sum8;
   logic       cout8;

   logic       start3;
   logic [2:0] a3;
   logic [2:0] b3;
   logic       busy3;
   logic       done3;
   logic [2:0] sum3;
   logic       cout3;

`ifdef SERIAL_SUB_EN
   logic       sub8;
   logic       sub3;
   localparam int NSUB = 2;
`else
   localparam int NSUB = 1;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   serial_add_sub #(.WIDTH(8)) u_dut8 (
      .clk       (clk),
      .rst       (rst),
      .start     (start8),
      .a         (a8),
      .b         (b8),
`ifdef SERIAL_SUB_EN
      .sub       (sub8),
`endif
      .busy      (busy8),
      .done      (done8),
      .sum       (sum8),
      .carry_out (cout8)
   );

   serial_add_sub #(.WIDTH(3)) u_dut3 (
      .clk       (clk),
      .rst       (rst),
      .start     (start3),
      .a         (a3),
      .b         (b3),
`ifdef SERIAL_SUB_EN
      .sub       (sub3),
`endif
      .busy      (busy3),
      .done      (done3),
      .sum       (sum3),
      .carry_out (cout3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One WIDTH=8 operation: accept, scramble inputs, wait (bounded) for done, check result.
   task automatic run8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_sum, input logic exp_c, input string tag);
      int lat;
      @(negedge clk);
      a8 = a; b8 = b; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0; a8 = ~a; b8 = 8'h5A;
      lat = 1;
      check({tag, "_busy"}, 32'(busy8), 32'd1);
      while (!done8 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'd9);
      check({tag, "_sum"}, 32'(sum8), 32'(exp_sum));
      check({tag, "_cout"}, 32'(cout8), 32'(exp_c));
   endtask

   initial begin
      int ndone;
      logic [7:0] s_got;
      logic       c_got;
      logic [3:0] e4;
      int lat;

      rst = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
      start3 = 1'b0; a3 = '0; b3 = '0;
`ifdef SERIAL_SUB_EN
      sub8 = 1'b0; sub3 = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy8), 32'd0);
      check("rst_done", 32'(done8), 32'd0);
      check("rst_sum",  32'(sum8),  32'd0);
      check("rst_cout", 32'(cout8), 32'd0);
      rst = 1'b0;

      // Basic add, then result hold in IDLE
      run8(8'h35, 8'h4A, 8'h7F, 1'b0, "add1");
      @(negedge clk);
      check("add1_done_low", 32'(done8), 32'd0);
      check("add1_busy_low", 32'(busy8), 32'd0);
      check("add1_hold",     32'(sum8),  32'h7F);

      // Overflow, then back-to-back start the cycle after done
      run8(8'hFF, 8'h01, 8'h00, 1'b1, "ovf");
      run8(8'h12, 8'h34, 8'h46, 1'b0, "b2b");
      run8(8'h80, 8'h80, 8'h00, 1'b1, "msb");

      // Start pulsed during RUN is ignored
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      ndone = 0; s_got = '0; c_got = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         if (done8) begin
            ndone++;
            s_got = sum8;
            c_got = cout8;
         end
         if (i == 3) begin
            a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
         end
         if (i == 4) start8 = 1'b0;
         @(negedge clk);
      end
      check("ign_ndone", 32'(ndone), 32'd1);
      check("ign_sum",   32'(s_got), 32'h46);
      check("ign_cout",  32'(c_got), 32'd0);

      // Reset in the middle of RUN discards the operation
      a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_busy", 32'(busy8), 32'd0);
      check("mrst_done", 32'(done8), 32'd0);
      check("mrst_sum",  32'(sum8),  32'd0);
      check("mrst_cout", 32'(cout8), 32'd0);
      ndone = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      check("mrst_nodone", 32'(ndone), 32'd0);
      run8(8'hAA, 8'h55, 8'hFF, 1'b0, "after_rst");

`ifdef SERIAL_SUB_EN
      sub8 = 1'b1;
      run8(8'h10, 8'h01, 8'h0F, 1'b1, "sub_nb");
      run8(8'h00, 8'h01, 8'hFF, 1'b0, "sub_bor");
      sub8 = 1'b0;
`endif

      // WIDTH=3 exhaustive sweep
      for (int s = 0; s < NSUB; s++) begin
         for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
               @(negedge clk);
               a3 = 3'(ai); b3 = 3'(bi); start3 = 1'b1;
`ifdef SERIAL_SUB_EN
               sub3 = (s != 0);
`endif
               @(negedge clk);
               start3 = 1'b0; a3 = ~a3;
               lat = 1;
               while (!done3 && lat < 10) begin
                  @(negedge clk);
                  lat++;
               end
               if (s != 0) e4 = {1'b0, 3'(ai)} + {1'b0, ~3'(bi)} + 4'd1;
               else        e4 = {1'b0, 3'(ai)} + {1'b0, 3'(bi)};
               check($sformatf("w3_s%0d_a%0d_b%0d", s, ai, bi),
                     {23'd0, 5'(lat), cout3, sum3}, {23'd0, 5'd4, e4});
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
